// File: rtl/filter_match_if.sv
// filter_match_if: candidate handshake, result and table-load signals of filter_match_engine.
// FILTER_MATCH_MASK_EN adds the i_match_mask compare mask.
interface filter_match_if #(
    parameter int FILTER_LENGTH = 1024,
    parameter int DATA_WIDTH = 64,
    parameter int LANES = 4
);
    localparam int IW = $clog2(FILTER_LENGTH);
    logic i_data_valid;
    logic [DATA_WIDTH-1:0] i_data;
    logic i_result_reset;
    logic o_result_valid;
    logic o_result_match;
    logic [DATA_WIDTH-1:0] o_result_data;
    logic [IW-1:0] o_result_index;
    logic o_shift_result_valid;
    logic [IW:0] i_filter_len;
    logic i_filt_we;
    logic [IW-1:0] i_filt_addr;
    logic [DATA_WIDTH-1:0] i_filt_wdata;
    logic o_busy;
`ifdef FILTER_MATCH_MASK_EN
    logic [DATA_WIDTH-1:0] i_match_mask;
    modport master(output i_data_valid, i_data, i_result_reset, i_filter_len, i_filt_we, i_filt_addr, i_filt_wdata, i_match_mask,
                   input o_result_valid, o_result_match, o_result_data, o_result_index, o_shift_result_valid, o_busy);
    modport slave(input i_data_valid, i_data, i_result_reset, i_filter_len, i_filt_we, i_filt_addr, i_filt_wdata, i_match_mask,
                  output o_result_valid, o_result_match, o_result_data, o_result_index, o_shift_result_valid, o_busy);
`else
    modport master(output i_data_valid, i_data, i_result_reset, i_filter_len, i_filt_we, i_filt_addr, i_filt_wdata,
                   input o_result_valid, o_result_match, o_result_data, o_result_index, o_shift_result_valid, o_busy);
    modport slave(input i_data_valid, i_data, i_result_reset, i_filter_len, i_filt_we, i_filt_addr, i_filt_wdata,
                  output o_result_valid, o_result_match, o_result_data, o_result_index, o_shift_result_valid, o_busy);
`endif
endinterface

// File: rtl/filter_match_engine.sv
// filter_match_engine: scans a LANES-wide banked filter table for a candidate, holding the lowest-index hit.
// Optional FILTER_MATCH_MASK_EN: lanes compare only the bits set in the latched i_match_mask.
module filter_match_engine #(
    parameter int FILTER_LENGTH = 1024,
    parameter int DATA_WIDTH = 64,
    parameter int LANES = 4
) (
    input logic i_fclk,
    input logic i_reset_n,
    filter_match_if.slave bus
);
    localparam int IW = $clog2(FILTER_LENGTH);
    localparam int LB = $clog2(LANES);
    localparam int RW = IW - LB;
    localparam int ROWS = FILTER_LENGTH / LANES;
    localparam logic [IW:0] ONE = 1;
    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
    state_t state, state_n;
    logic [DATA_WIDTH-1:0] cand, mask, c_data;
    logic [DATA_WIDTH-1:0] lane_q [LANES];
    logic [IW:0] len, resume, nxt;
    logic [RW-1:0] rd_row, q_row, last_row;
    logic [IW-1:0] c_idx;
    logic [LANES-1:0] lane_hit;
    logic [LB-1:0] hit_lane;
    logic rd_done, q_v, q_z, c_v, c_hit, c_last;
    logic go, rs, fin_hit, fin_miss, scanning, issue;

    assign last_row = RW'((len - ONE) >> LB);
    assign nxt = {1'b0, bus.o_result_index} + ONE;
    assign go = state == IDLE && bus.i_data_valid;
    assign rs = state == HOLD && bus.i_data_valid && bus.i_result_reset && bus.o_result_match;
    assign fin_hit = state == SCAN && bus.i_data_valid && c_v && c_hit;
    assign fin_miss = state == SCAN && bus.i_data_valid && (q_z || (c_v && !c_hit && c_last));
    assign scanning = state == SCAN && state_n == SCAN;
    assign issue = scanning && !rd_done;
    assign bus.o_busy = state != IDLE;
    assign bus.o_shift_result_valid = c_v;

`ifdef FILTER_MATCH_MASK_EN
    always_ff @(posedge i_fclk) if (go) mask <= bus.i_match_mask;
`else
    assign mask = '1;
`endif

    for (genvar b = 0; b < LANES; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [ROWS];
        logic [DATA_WIDTH-1:0] q;
        logic [IW:0] e;
        always_ff @(posedge i_fclk) begin
            if (bus.i_filt_we && state == IDLE && bus.i_filt_addr[LB-1:0] == LB'(b)) mem[bus.i_filt_addr[IW-1:LB]] <= bus.i_filt_wdata;
            if (issue) q <= mem[rd_row];
        end
        assign e = {1'b0, q_row, LB'(b)};
        assign lane_q[b] = q;
        // the window excludes entries past the valid length and those already reported before a resume
        assign lane_hit[b] = e < len && e >= resume && ((cand ^ q) & mask) == '0;
    end

    always_comb begin
        hit_lane = '0;
        for (int l = LANES - 1; l >= 0; l--) if (lane_hit[l]) hit_lane = LB'(l);
    end

    always_comb begin
        state_n = state;
        if (!bus.i_data_valid) state_n = IDLE;
        else if (go || rs) state_n = SCAN;
        else if (fin_hit || fin_miss) state_n = HOLD;
    end

    always_ff @(posedge i_fclk) state <= !i_reset_n ? IDLE : state_n;

    always_ff @(posedge i_fclk) begin
        if (!i_reset_n) begin
            rd_row <= '0;
            resume <= '0;
            rd_done <= 1'b0;
            q_v <= 1'b0;
            q_z <= 1'b0;
            c_v <= 1'b0;
            bus.o_result_valid <= 1'b0;
            bus.o_result_match <= 1'b0;
            bus.o_result_data <= '0;
            bus.o_result_index <= '0;
        end else begin
            if (go) begin
                cand <= bus.i_data;
                len <= bus.i_filter_len;
                resume <= '0;
                rd_row <= '0;
            end
            // a resume past the last valid entry rescans the last row fully masked, giving a plain miss
            if (rs) begin
                resume <= nxt;
                rd_row <= nxt >= len ? last_row : nxt[IW-1:LB];
            end
            if (issue) rd_row <= rd_row + RW'(1);
            rd_done <= scanning && (rd_done || len == '0 || rd_row == last_row);
            q_v <= issue && len != '0;
            q_z <= issue && len == '0;
            q_row <= rd_row;
            c_v <= scanning && q_v;
            c_hit <= |lane_hit;
            c_last <= q_row == last_row;
            c_idx <= {q_row, hit_lane};
            c_data <= lane_q[hit_lane];
            if (fin_hit || fin_miss) begin
                bus.o_result_valid <= 1'b1;
                bus.o_result_match <= fin_hit;
                bus.o_result_data <= fin_hit ? c_data : '0;
                bus.o_result_index <= fin_hit ? c_idx : '0;
            end else if (state == HOLD && state_n != HOLD) begin
                bus.o_result_valid <= 1'b0;
                bus.o_result_match <= 1'b0;
                bus.o_result_data <= '0;
                bus.o_result_index <= '0;
            end
        end
    end
endmodule

// File: doc/filter_match_engine.md
Name: filter_match_engine

Overview:
- Responder side of the matcher handshake: accepts a candidate word under i_data_valid and scans a loadable filter table LANES entries per cycle.
- Presents a held match/no-match result and pulses o_shift_result_valid once per compared group.
- Sits between the LFSR candidate source and the matching controller; software loads the table through a simple write port.

Parameters:
- FILTER_LENGTH, 1024, table depth in entries; must be a multiple of LANES.
- DATA_WIDTH, 64, width of candidate and entry.
- LANES, 4, entries compared per cycle (power of 2).

Ports:
- i_fclk  in  1  clock
- i_reset_n  in  1  reset; synchronous, active-low, sampled on i_fclk
- i_data_valid  in  1  level; candidate valid; low for >=1 cycle means the candidate is withdrawn
- i_data  in  DATA_WIDTH  candidate word; sampled only on IDLE->SCAN
- i_result_reset  in  1  acknowledge a match and resume the scan
- o_result_valid  out  1  result held (level)
- o_result_match  out  1  1 = match, 0 = table exhausted
- o_result_data  out  DATA_WIDTH  matched table entry; 0 on no-match
- o_result_index  out  $clog2(FILTER_LENGTH)  matched entry index; 0 on no-match
- o_shift_result_valid  out  1  1-cycle pulse per group compared
- i_filter_len  in  $clog2(FILTER_LENGTH)+1  number of valid entries, 0..FILTER_LENGTH; sampled on IDLE->SCAN
- i_filt_we  in  1  table write strobe
- i_filt_addr  in  $clog2(FILTER_LENGTH)  write address
- i_filt_wdata  in  DATA_WIDTH  write data
- o_busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, internal index 0. Table contents are not cleared.
- Table storage:
  - LANES banks with synchronous read, 1-cycle latency.
  - Entry e lives in bank e mod LANES, row e/LANES.
  - Writes take effect only while in IDLE; writes in other states are dropped.
- States: IDLE, SCAN, HOLD.
- IDLE -> SCAN when i_data_valid=1. On that edge (cycle t): latch i_data and i_filter_len, set start index 0.
- SCAN pipeline:
  - Row read issued each cycle from t+1.
  - Compare on bank output the following cycle.
  - o_shift_result_valid pulses in that compare cycle: first pulse at t+2 for group 0.
- Group compare:
  - Each lane's entry index must be < latched length and >= resume index; lanes outside this window are masked.
  - Lowest-index hit wins.
- Hit in group g (starting from 0):
  - o_result_valid=1, o_result_match=1, o_result_data/o_result_index registered at t+3+g.
  - Enter HOLD; discard in-flight speculative reads.
- Exhausted (last valid group compared, no hit): o_result_valid=1 and o_result_match=0 one cycle after the final compare; enter HOLD.
- i_filter_len=0: no compares, no shift pulses; o_result_valid=1, o_result_match=0 at t+2.
- HOLD: outputs held stable until exit.
  - i_result_reset=1: clear o_result_*; resume index = matched index+1; return to SCAN at the row containing it. The next shift pulse comes 2 cycles after the reset.
  - If the matched index is the last valid entry, the resume immediately yields a no-match with the exhausted timing.
  - i_data_valid=0: clear o_result_*; go to IDLE.
  - Both in the same cycle: i_data_valid=0 wins.
- i_data_valid falls during SCAN: abort in the next cycle, no result, go to IDLE; pulses already issued stand.
- i_result_reset outside HOLD: ignored.
- Synchronous reset mid-scan: state returns to IDLE, outputs cleared in the same edge.
- Index arithmetic is unsigned; no wrap. The scan never reads past row (len-1)/LANES.

Optional Feature:
- Macro FILTER_MATCH_MASK_EN.
- Defined:
  - Adds input i_match_mask [DATA_WIDTH], latched with i_data on IDLE->SCAN.
  - A lane hits when ((candidate ^ entry) & mask) == 0.
  - o_result_data returns the stored entry, which may differ from the candidate in masked bits.
- Undefined: the port is absent and compare is exact equality.

Test Plan:
- Load entries 0..7 = 0x10..0x17, i_filter_len=8, LANES=4; i_data_valid=1 with i_data=0x16 at t -> shift pulses at t+2, t+3; o_result_valid/o_result_match=1 at t+4; o_result_index=6; o_result_data=0x16.
- Same table, i_data=0x99 -> two shift pulses; o_result_valid=1, o_result_match=0, o_result_data=0 at t+4; drop i_data_valid one cycle -> IDLE, o_result_valid=0 next cycle.
- Entries 1 and 5 = 0xAB, len=8, i_data=0xAB -> index 1 reported; pulse i_result_reset -> second result index 5; reset again -> o_result_match=0.
- i_filter_len=0 -> o_result_valid=1, o_result_match=0 at t+2, zero shift pulses.
- FILTER_LENGTH=1024, no hit -> exactly 256 shift pulses; i_filt_we pulsed during SCAN does not alter the table.
- Assert i_reset_n=0 mid-SCAN -> all outputs 0 and o_busy=0 after the edge; a new i_data_valid is accepted normally.
